// File: rtl/diff_rebuild.sv
// Rebuilds a word from a base by toggling a stream of bit indices.
// Latency: first index 1 cycle after start; res_valid 1 cycle after the last index is accepted.
// Backpressure: pos_ready is high only while collecting; the result is held until res_ready.
module diff_rebuild #(
    parameter int WIDTH  = 32,
    parameter int IDXW   = 5,
    parameter int MAXPOS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic             pos_valid,
    input  logic [IDXW-1:0]  pos_idx,
    input  logic             pos_last,
    output logic             pos_ready,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       count,
    output logic             overflow
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_FULL,
        S_OUT
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] r_result;
    logic [3:0]       r_count;
    logic             r_overflow;
    logic             w_accept;
    logic             w_at_limit;
    logic [WIDTH-1:0] w_toggled;

    // An index is taken only while collecting; pos_ready is high exactly then.
    assign w_accept   = (r_state == S_COLLECT) && pos_valid;
    // This accept fills the last free slot.
    assign w_at_limit = (r_count == 4'(MAXPOS - 1));
    assign w_toggled  = r_work ^ ({{(WIDTH-1){1'b0}}, 1'b1} << pos_idx);

    assign result   = r_result;
    assign count    = r_count;
    assign overflow = r_overflow;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake outputs; pos_last always ends the job, even past the limit.
    always_comb begin
        w_next    = r_state;
        pos_ready = 1'b0;
        busy      = 1'b1;
        res_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = S_COLLECT;
                end
            end
            S_COLLECT: begin
                pos_ready = 1'b1;
                if (w_accept) begin
                    if (pos_last) begin
                        w_next = S_OUT;
                    end else if (w_at_limit) begin
                        w_next = S_FULL;
                    end
                end
            end
            S_FULL: begin
                if (pos_valid && pos_last) begin
                    w_next = S_OUT;
                end
            end
            S_OUT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Work word, count, sticky overflow, and the result latched on entry to OUT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_work     <= '0;
            r_result   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_work     <= base;
                        r_count    <= '0;
                        r_overflow <= 1'b0;
                    end
                end
                S_COLLECT: begin
                    if (w_accept) begin
                        r_work  <= w_toggled;
                        r_count <= r_count + 4'd1;
                        if (pos_last) begin
                            r_result <= w_toggled;
                        end
                    end
                end
                S_FULL: begin
                    // Offered indices are refused here; the last one still closes the job.
                    if (pos_valid) begin
                        r_overflow <= 1'b1;
                        if (pos_last) begin
                            r_result <= r_work;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_diff_rebuild.sv
module tb_diff_rebuild;

    localparam int MAXPOS = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] base;
    logic        pos_valid;
    logic [4:0]  pos_idx;
    logic        pos_last;
    logic        pos_ready;
    logic        busy;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] result;
    logic [3:0]  count;
    logic        overflow;

    int tests = 0;
    int fails = 0;
    logic [31:0] last_res;

    diff_rebuild dut (
        .clk(clk), .rst(rst), .start(start), .base(base),
        .pos_valid(pos_valid), .pos_idx(pos_idx), .pos_last(pos_last),
        .pos_ready(pos_ready), .busy(busy), .res_valid(res_valid),
        .res_ready(res_ready), .result(result), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] b;
        logic [79:0] iv;   // index i lives at bits [5*i +: 5]
        int          n;
        logic [31:0] er;
        logic [3:0]  ec;
        logic        eo;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: a bit flips iff it was named an odd number of times among the accepted indices.
    function automatic logic [31:0] model(input logic [31:0] b, input logic [79:0] iv, input int n);
        int hits[32];
        int m;
        logic [31:0] r;
        m = (n > MAXPOS) ? MAXPOS : n;
        for (int k = 0; k < 32; k++) hits[k] = 0;
        for (int i = 0; i < m; i++) hits[iv[5*i +: 5]]++;
        r = b;
        for (int k = 0; k < 32; k++) if (hits[k] % 2 == 1) r[k] = ~r[k];
        return r;
    endfunction

    task automatic run_job(input logic [31:0] b, input logic [79:0] iv, input int n,
                           input logic [31:0] er, input logic [3:0] ec, input logic eo,
                           input int hold, input bit gaps, input bit early);
        @(negedge clk);
        start = 1'b1; base = b;
        pos_valid = 1'b1; pos_idx = 5'($urandom_range(0, 31)); pos_last = 1'b0;
        @(negedge clk);
        start = 1'b0; pos_valid = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("count_cleared", {28'd0, count}, 32'd0);
        if (early) res_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                pos_valid = 1'b0;
                @(negedge clk);
            end
            pos_valid = 1'b1; pos_idx = iv[5*i +: 5]; pos_last = (i == n - 1);
            chk("pos_ready_offer", {31'd0, pos_ready}, {31'd0, (i < MAXPOS)});
            chk("no_early_valid", {31'd0, res_valid}, 32'd0);
            @(negedge clk);
        end
        pos_valid = 1'b0; pos_last = 1'b0;
        chk("res_valid_latency", {31'd0, res_valid}, 32'd1);
        chk("result", result, er);
        chk("count", {28'd0, count}, {28'd0, ec});
        chk("overflow", {31'd0, overflow}, {31'd0, eo});
        last_res = result;
        if (!early) begin
            for (int k = 0; k < hold; k++) begin
                start = (k == 1);
                base = ~b;
                @(negedge clk);
                chk("hold_valid", {31'd0, res_valid}, 32'd1);
                chk("hold_result", result, er);
            end
            start = 1'b0;
            res_ready = 1'b1;
        end
        @(negedge clk);
        res_ready = 1'b0;
        chk("valid_drop", {31'd0, res_valid}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_result_held", result, er);
        chk("idle_count_held", {28'd0, count}, {28'd0, ec});
    endtask

    initial begin
        logic [31:0] diffv;
        int          low;
        logic [79:0] iv;
        int          n;
        logic [31:0] b;

        rst = 1'b1; start = 1'b0; base = '0; pos_valid = 1'b0;
        pos_idx = '0; pos_last = 1'b0; res_ready = 1'b0;

        vecs[0] = '{32'h0000000A, 80'({5'd2, 5'd0}), 2, 32'h0000000F, 4'd2, 1'b0};
        vecs[1] = '{32'd10, 80'(5'd0), 1, 32'd11, 4'd1, 1'b0};
        vecs[2] = '{32'd7, 80'(5'd31), 1, 32'h80000007, 4'd1, 1'b0};
        vecs[3] = '{32'hFFFFFFFF, 80'({5'd31, 5'd5, 5'd5}), 3, 32'h7FFFFFFF, 4'd3, 1'b0};
        vecs[4] = '{32'h12345678,
                    80'({5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0}),
                    9, 32'h12345687, 4'd8, 1'b1};

        #12;
        chk("rst_result", result, 32'd0);
        chk("rst_count", {28'd0, count}, 32'd0);
        chk("rst_flags", {28'd0, pos_ready, busy, res_valid, overflow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            run_job(vecs[v].b, vecs[v].iv, vecs[v].n, vecs[v].er, vecs[v].ec, vecs[v].eo,
                    (v == 0) ? 5 : 1, 1'b0, (v == 2));
            if (vecs[v].n == 1) begin
                diffv = last_res ^ vecs[v].b;
                low = 32;
                for (int k = 31; k >= 0; k--) if (diffv[k]) low = k;
                chk("diff_lowest_bit", 32'(low), 32'(vecs[v].iv[4:0]));
            end
        end

        // Abort mid-collect: reset must clear everything immediately.
        @(negedge clk);
        start = 1'b1; base = 32'hDEADBEEF;
        @(negedge clk);
        start = 1'b0; pos_valid = 1'b1; pos_idx = 5'd1;
        @(negedge clk);
        pos_idx = 5'd2;
        @(negedge clk);
        pos_valid = 1'b0;
        chk("pre_abort_count", {28'd0, count}, 32'd2);
        rst = 1'b1;
        #1;
        chk("abort_result", result, 32'd0);
        chk("abort_count", {28'd0, count}, 32'd0);
        chk("abort_flags", {28'd0, pos_ready, busy, res_valid, overflow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_job(vecs[0].b, vecs[0].iv, vecs[0].n, vecs[0].er, vecs[0].ec, vecs[0].eo, 0, 1'b0, 1'b0);

        for (int j = 0; j < 40; j++) begin
            b = $urandom;
            n = $urandom_range(1, 12);
            iv = '0;
            for (int i = 0; i < n; i++)
                iv[5*i +: 5] = (j % 3 == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            run_job(b, iv, n, model(b, iv, n), 4'((n > MAXPOS) ? MAXPOS : n), (n > MAXPOS),
                    $urandom_range(0, 3), 1'b1, ($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/diff_rebuild.md
Name: diff_rebuild

Overview:
- Inverse-direction companion to the combinational Diff unit in the miniRISC datapath.
- Diff reports the lowest bit index at which two 32-bit words differ. diff_rebuild takes a base word plus a stream of 5-bit bit indices and toggles each indexed bit. It returns the rebuilt 32-bit word through a valid/ready result handshake.
- Used by the multi-cycle execute path and by the bench to generate golden operand pairs for Diff.

Parameters:
- WIDTH, 32, data word width; must be 32 for miniRISC.
- IDXW, 5, bit-index width, equal to log2(WIDTH).
- MAXPOS, 8, maximum number of indices accepted per job; indices beyond this are refused (see FULL).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a job; honoured only in IDLE.
- base  in  WIDTH  base word, sampled when start is accepted.
- pos_valid  in  1  pos_idx is valid this cycle.
- pos_idx  in  IDXW  index of the bit to toggle.
- pos_last  in  1  marks the final index of the job, qualified by pos_valid.
- pos_ready  out  1  block can accept an index.
- busy  out  1  a job is in progress (state is not IDLE).
- res_valid  out  1  result is available.
- res_ready  in  1  consumer accepts the result.
- result  out  WIDTH  rebuilt word.
- count  out  4  number of indices accepted in the current or last job (0..MAXPOS).
- overflow  out  1  sticky flag: an index was offered while count == MAXPOS; cleared by the next accepted start.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE.
  - result = 0, count = 0, overflow = 0.
  - pos_ready = 0, res_valid = 0, busy = 0.
- States: IDLE, COLLECT, FULL, OUT.
- IDLE:
  - start = 1: work register <= base, count <= 0, overflow <= 0, go to COLLECT next cycle.
  - pos_valid is ignored in IDLE.
- COLLECT:
  - pos_ready = 1.
  - Each accepted index (pos_valid && pos_ready) updates work <= work ^ (1 << pos_idx) and count <= count + 1.
  - Duplicate indices toggle the bit again, so two hits on the same index cancel.
  - pos_last accepted: go to OUT next cycle.
  - Otherwise, count reaching MAXPOS after this accept: go to FULL.
- FULL:
  - pos_ready = 0.
  - Any pos_valid sets overflow = 1 and the index is discarded.
  - pos_valid && pos_last: go to OUT; its index is still discarded.
- OUT:
  - res_valid = 1 and result = work.
  - Result stays stable until res_valid && res_ready, then go to IDLE on the next cycle.
  - res_valid drops in that same next cycle.
- Latency:
  - First index can be accepted 1 cycle after start.
  - res_valid rises 1 cycle after pos_last is accepted.
  - Zero-index job (pos_last with no valid index) is not possible: pos_last is only qualified by pos_valid.
- start outside IDLE is ignored; busy = 1 in COLLECT, FULL and OUT.
- result holds its last value in IDLE; it only changes on entry to OUT.
- Index width rule: pos_idx is unsigned 0..31. No range error is possible.
- Reset during any state aborts the job with no result emitted; all outputs return to their reset values.
- Simultaneous events:
  - start with pos_valid in IDLE: start wins and the index is dropped.
  - res_ready held high before OUT: the handshake completes in the first OUT cycle.

Test Plan:
- Reset check: assert rst mid-COLLECT after 2 indices -> next edge shows res_valid=0, busy=0, result=0, count=0; a following job runs normally.
- Basic rebuild: start with base=0x0000000A, indices {0,2} with last on 2 -> result=0x0000000F, count=2, res_valid exactly 1 cycle after the last accept.
- Diff cross-check: base=10, index {0}, last -> result=11; feed (10, 11) to Diff -> out=0. Base=7, index {31} -> result=0x80000007.
- Duplicate cancel: base=0xFFFFFFFF, indices {5,5,31} -> result=0x7FFFFFFF, count=3.
- Overflow: MAXPOS=8, offer 9 indices {0..8}, last on 8 -> result=base^0xFF, count=8, overflow=1, and pos_ready=0 during the 9th offer.
- Backpressure: hold res_ready=0 for 5 cycles in OUT -> result and res_valid stable; start pulses during OUT are ignored; raise res_ready -> IDLE next cycle.
